// File: rtl/osf_pipe_arbiter_if.sv
// Pipe-FIFO side of the oversample-filter arbiter: word strobe, word, and FIFO ready.
interface osf_pipe_arbiter_if #(
    parameter int W_EP = 16
);
    logic            pipe_dv_out;
    logic [W_EP-1:0] pipe_data_out;
    logic            fifo_ready_in;

    modport master (output pipe_dv_out, output pipe_data_out, input fifo_ready_in);
    modport slave  (input pipe_dv_out, input pipe_data_out, output fifo_ready_in);
endinterface

// File: rtl/osf_pipe_arbiter.sv
// Shares the bulk-transfer pipe FIFO among all oversample-filter channels using
// one-deep per-channel sample slots and a round-robin (header, data) framer.
module osf_pipe_arbiter #(
    parameter int N_ADC      = 8,
    parameter int W_ADC_DATA = 18,
    parameter int W_EP       = 16,
    parameter int W_DROP     = 16
) (
    input  logic                          clk50_in,
    input  logic                          sys_reset_out,
    input  logic                          flush_in,
    input  logic [N_ADC-1:0]              chan_en_in,
    input  logic [N_ADC-1:0]              osf_data_valid_in,
    input  logic [N_ADC*W_ADC_DATA-1:0]   osf_data_packed_in,
    input  logic                          drop_clear_in,
    output logic [N_ADC-1:0]              pending_out,
    output logic [W_DROP-1:0]             drop_count_out,
    osf_pipe_arbiter_if.master            pipe
);
    localparam int W_PTR = $clog2(N_ADC);
    localparam int W_SUM = W_DROP + 5;

    typedef enum logic [1:0] {IDLE, HDR, DAT} state_t;

    state_t                state;
    logic [W_ADC_DATA-1:0] slot [N_ADC];
    logic [N_ADC-1:0]      pending;
    logic [N_ADC-1:0]      capture;
    logic [N_ADC-1:0]      consume;
    logic [N_ADC-1:0]      drop_vec;
    logic [N_ADC-1:0]      pending_next;
    logic [W_PTR-1:0]      rr_ptr;
    logic [W_PTR-1:0]      grant;
    logic [W_PTR-1:0]      next_ptr;
    logic [W_PTR-1:0]      chan_reg;
    logic                  any_pending;
    logic [W_EP-1:0]       data_reg;
    logic [W_EP-1:0]       hdr_word;
    logic [3:0]            chan_tag;
    logic [W_DROP-1:0]     drop_count;
    logic [W_DROP-1:0]     drop_base;
    logic [W_DROP-1:0]     drop_next;
    logic [W_SUM-1:0]      drop_sum;

    assign pending_out    = pending;
    assign drop_count_out = drop_count;
    assign any_pending    = |pending;
    assign next_ptr       = (grant == W_PTR'(N_ADC - 1)) ? '0 : grant + 1'b1;
    assign chan_tag       = 4'(chan_reg);

    // Descending scan so the last hit is the first pending channel at or after rr_ptr.
    always_comb begin : grant_search
        int idx;
        idx   = 0;
        grant = '0;
        for (int i = N_ADC - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_ADC;
            if (pending[idx]) grant = W_PTR'(idx);
        end
    end

    always_comb begin
        capture = osf_data_valid_in & chan_en_in & {N_ADC{~flush_in}};
        consume = '0;
        for (int c = 0; c < N_ADC; c++) begin
            consume[c] = (state == IDLE) && pending[c] && (grant == W_PTR'(c));
        end
        drop_vec     = capture & pending & ~consume;
        pending_next = flush_in ? '0 : (((pending & ~consume) | capture) & chan_en_in);
    end

    // Every simultaneous overwrite counts; the sum is widened so saturation is exact.
    always_comb begin
        drop_base = drop_clear_in ? '0 : drop_count;
        drop_sum  = W_SUM'(drop_base) + W_SUM'($countones(drop_vec));
        drop_next = (|drop_sum[W_SUM-1:W_DROP]) ? '1 : drop_sum[W_DROP-1:0];
    end

    always_comb begin
        hdr_word              = '0;
        hdr_word[W_EP-1 -: 4] = 4'hA;
        hdr_word[3:0]         = chan_tag;
    end

    always_ff @(posedge clk50_in or posedge sys_reset_out) begin
        if (sys_reset_out) begin
            pending    <= '0;
            drop_count <= '0;
            for (int c = 0; c < N_ADC; c++) slot[c] <= '0;
        end else begin
            pending    <= pending_next;
            drop_count <= drop_next;
            for (int c = 0; c < N_ADC; c++) begin
                if (capture[c]) slot[c] <= osf_data_packed_in[c*W_ADC_DATA +: W_ADC_DATA];
            end
        end
    end

    // Data is latched at grant time, so later captures or enable changes cannot alter the frame.
    always_ff @(posedge clk50_in or posedge sys_reset_out) begin
        if (sys_reset_out) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            chan_reg           <= '0;
            data_reg           <= '0;
            pipe.pipe_dv_out   <= 1'b0;
            pipe.pipe_data_out <= '0;
        end else begin
            pipe.pipe_dv_out <= 1'b0;
            if (flush_in) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (any_pending) begin
                            chan_reg <= grant;
                            data_reg <= slot[grant][W_ADC_DATA-1 -: W_EP];
                            rr_ptr   <= next_ptr;
                            state    <= HDR;
                        end
                    end
                    HDR: begin
                        if (pipe.fifo_ready_in) begin
                            pipe.pipe_dv_out   <= 1'b1;
                            pipe.pipe_data_out <= hdr_word;
                            state              <= DAT;
                        end
                    end
                    DAT: begin
                        if (pipe.fifo_ready_in) begin
                            pipe.pipe_dv_out   <= 1'b1;
                            pipe.pipe_data_out <= data_reg;
                            state              <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    if (W_ADC_DATA > W_EP) begin : g_low_bits
        logic unused_slot_low;
        always_comb begin
            unused_slot_low = 1'b0;
            for (int c = 0; c < N_ADC; c++) begin
                unused_slot_low = unused_slot_low ^ (^slot[c][W_ADC_DATA-W_EP-1:0]);
            end
        end
    end
endmodule
